// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port (read-only) and the load/store port (read/write).
// One transaction is in flight at a time. Sequence per access:
// IDLE (grant) -> ACCESS -> [RDWAIT for reads] -> RESP -> IDLE.
// Optional build macro RAM_ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate between the two ports; otherwise the LSU always wins.
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  lsu_req_i,
   input  logic                  lsu_we_i,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   output logic                  lsu_gnt_o,
   output logic                  lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0] lsu_rdata_o,
   output logic                  ram_cs_o,
   output logic                  ram_we_o,
   output logic                  ram_oe_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   inout  wire  [DATA_WIDTH-1:0] ram_data_io
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                  state_q;
   logic                    owner_lsu_q;
   logic                    we_q;
   logic                    drive_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    arb_en;
   logic                    lsu_sel;
   logic                    if_sel;
   logic                    accept;

   // Grants are only offered in IDLE, and never while reset is asserted.
   assign arb_en = (state_q == IDLE) && rst_n_i;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // High when the LSU should win the next tie (i.e. IF was granted last).
   logic prefer_lsu_q;

   assign lsu_sel = lsu_req_i && (!if_req_i || prefer_lsu_q);

   // Remember who was granted so the other requester wins the next tie.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prefer_lsu_q <= 1'b1;
      end else if (accept) begin
         prefer_lsu_q <= if_sel;
      end
   end
`else
   assign lsu_sel = lsu_req_i;
`endif

   assign if_sel    = if_req_i && !lsu_sel;
   assign lsu_gnt_o = arb_en && lsu_sel;
   assign if_gnt_o  = arb_en && if_sel;
   assign accept    = lsu_gnt_o || if_gnt_o;

   // The bus is driven only for the single ACCESS cycle of a write.
   assign ram_data_io = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   // Write data is a pure datapath register, loaded at the accepting edge.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         wdata_q <= lsu_wdata_i;
      end
   end

   // Transaction sequencer: owns the RAM strobes, responses and read capture.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         owner_lsu_q  <= 1'b0;
         we_q         <= 1'b0;
         drive_q      <= 1'b0;
         ram_cs_o     <= 1'b0;
         ram_we_o     <= 1'b0;
         ram_oe_o     <= 1'b0;
         ram_addr_o   <= '0;
         if_rvalid_o  <= 1'b0;
         lsu_rvalid_o <= 1'b0;
         if_rdata_o   <= '0;
         lsu_rdata_o  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  owner_lsu_q <= lsu_sel;
                  we_q        <= lsu_sel && lsu_we_i;
                  ram_addr_o  <= lsu_sel ? lsu_addr_i : if_addr_i;
                  ram_cs_o    <= 1'b1;
                  ram_we_o    <= lsu_sel && lsu_we_i;
                  ram_oe_o    <= !(lsu_sel && lsu_we_i);
                  drive_q     <= lsu_sel && lsu_we_i;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (we_q) begin
                  // Write lands in the RAM at this edge; acknowledge next.
                  ram_cs_o     <= 1'b0;
                  ram_we_o     <= 1'b0;
                  drive_q      <= 1'b0;
                  lsu_rvalid_o <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  // Hold cs/oe/addr so the RAM presents data during RDWAIT.
                  state_q <= RDWAIT;
               end
            end
            RDWAIT: begin
               if (owner_lsu_q) begin
                  lsu_rdata_o  <= ram_data_io;
                  lsu_rvalid_o <= 1'b1;
               end else begin
                  if_rdata_o  <= ram_data_io;
                  if_rvalid_o <= 1'b1;
               end
               ram_cs_o <= 1'b0;
               ram_oe_o <= 1'b0;
               state_q  <= RESP;
            end
            RESP: begin
               if_rvalid_o  <= 1'b0;
               lsu_rvalid_o <= 1'b0;
               state_q      <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized self-checking bench for ram_port_arbiter.
// A behavioural RAM sits on the tristate bus; a separate reference memory and
// simple latency / arbitration rules provide every expected value.
module tb_ram_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 8;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          lsu_req;
   logic          lsu_we;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata;
   logic          lsu_gnt;
   logic          lsu_rvalid;
   logic [DW-1:0] lsu_rdata;
   logic          ram_cs;
   logic          ram_we;
   logic          ram_oe;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram_mem [256];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] mdl_lsu_rdata;

   always #5 clk = ~clk;

   // Behavioural synchronous RAM: drives the bus while selected for read.
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_addr] : {DW{1'bz}};

   always @(posedge clk) begin
      if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
   end

   ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
      .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
      .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
      .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_oe_o(ram_oe),
      .ram_addr_o(ram_addr), .ram_data_io(ram_data)
   );

   function automatic logic [2*DW+2*AW+7:0] all_outs();
      return {if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
              ram_cs, ram_we, ram_oe, ram_addr, ram_addr};
   endfunction

   // Issues one request from an idle controller and records what happened.
   task automatic run_txn(input bit lsu, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int wait_c, output int lat,
                          output logic [DW-1:0] rdata, output int we_c,
                          output logic [2:0] acc_sig, output logic [AW-1:0] acc_addr,
                          output logic [DW-1:0] acc_bus, output int pulse,
                          output int clash_c);
      wait_c = -1; lat = 0; rdata = '0; we_c = 0; pulse = 0; clash_c = 0;
      acc_sig = '0; acc_addr = '0; acc_bus = '0;
      @(posedge clk); #1;
      if (lsu) begin
         lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (lsu ? lsu_gnt : if_gnt) begin
            wait_c = c;
            break;
         end
      end
      @(posedge clk); #1;
      lsu_req = 1'b0; if_req = 1'b0;
      lsu_wdata = $urandom; lsu_addr = AW'($urandom); if_addr = AW'($urandom);
      if (wait_c < 0) return;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            acc_sig = {ram_cs, ram_we, ram_oe}; acc_addr = ram_addr; acc_bus = ram_data;
         end
         if (ram_we) we_c++;
         if (ram_we && ram_oe) clash_c++;
         if (lsu ? lsu_rvalid : if_rvalid) begin
            if (lat == 0) begin
               lat = k;
               rdata = lsu ? lsu_rdata : if_rdata;
            end
            pulse++;
         end
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; if_req = 1'b0; lsu_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mdl_lsu_rdata = '0;
   endtask

   task automatic test_reset();
      logic [2*DW+2*AW+7:0] o;
      // Power-on reset
      #3;
      o = all_outs();
      checks++;
      if (o !== '0) begin errors++; $display("FAIL reset_por outs=%h required 0", o); end
      @(negedge clk); rst_n = 1'b1;
      // Asynchronous reset mid-write, checked before any clock edge.
      @(posedge clk); #1;
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 8'h44; lsu_wdata = 32'hA5A5_5A5A;
      @(posedge clk); #1;
      lsu_req = 1'b0;
      checks++;
      if (ram_we !== 1'b1) begin errors++; $display("FAIL reset_pre_we actual=%b required 1", ram_we); end
      #2 rst_n = 1'b0;
      #1;
      o = all_outs();
      checks++;
      if (o !== '0) begin errors++; $display("FAIL reset_async outs=%h required 0", o); end
      @(negedge clk); rst_n = 1'b1;
      mdl_lsu_rdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (ram_mem[8'h44] !== ref_mem[8'h44]) begin
         errors++; $display("FAIL reset_write_dropped mem=%h required %h", ram_mem[8'h44], ref_mem[8'h44]);
      end
   endtask

   task automatic test_if_read();
      int w, l, wc, p, cl; logic [DW-1:0] rd, bus; logic [2:0] s; logic [AW-1:0] a;
      run_txn(1'b0, 1'b0, 8'h10, '0, w, l, rd, wc, s, a, bus, p, cl);
      checks++; if (w !== 0) begin errors++; $display("FAIL if_gnt_wait actual=%0d required 0", w); end
      checks++; if (l !== 3) begin errors++; $display("FAIL if_latency actual=%0d required 3", l); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL if_rdata actual=%h required deadbeef", rd); end
      checks++; if (s !== 3'b101 || a !== 8'h10) begin errors++; $display("FAIL if_access csweoe=%b addr=%h required 101/10", s, a); end
      checks++; if (p !== 1 || wc !== 0 || cl !== 0) begin errors++; $display("FAIL if_pulse pulse=%0d we=%0d clash=%0d required 1/0/0", p, wc, cl); end
   endtask

   task automatic test_lsu_write_read();
      int w, l, wc, p, cl; logic [DW-1:0] rd, bus; logic [2:0] s; logic [AW-1:0] a;
      run_txn(1'b1, 1'b1, 8'h20, 32'h12345678, w, l, rd, wc, s, a, bus, p, cl);
      ref_mem[8'h20] = 32'h12345678;
      checks++; if (w !== 0 || l !== 2) begin errors++; $display("FAIL wr_timing wait=%0d lat=%0d required 0/2", w, l); end
      checks++; if (wc !== 1 || s !== 3'b110) begin errors++; $display("FAIL wr_strobes we_cycles=%0d csweoe=%b required 1/110", wc, s); end
      checks++; if (bus !== 32'h12345678) begin errors++; $display("FAIL wr_bus actual=%h required 12345678", bus); end
      checks++; if (rd !== mdl_lsu_rdata) begin errors++; $display("FAIL wr_rdata_hold actual=%h required %h", rd, mdl_lsu_rdata); end
      run_txn(1'b1, 1'b0, 8'h20, '0, w, l, rd, wc, s, a, bus, p, cl);
      mdl_lsu_rdata = ref_mem[8'h20];
      checks++; if (l !== 3 || rd !== 32'h12345678) begin errors++; $display("FAIL lsu_read lat=%0d data=%h required 3/12345678", l, rd); end
   endtask

   task automatic test_random();
      int w, l, wc, p, cl; logic [DW-1:0] rd, bus, wd; logic [2:0] s; logic [AW-1:0] a, addr;
      bit lsu, we;
      for (int i = 0; i < 40; i++) begin
         lsu = 1'($urandom); we = lsu && 1'($urandom); addr = AW'($urandom); wd = $urandom;
         if (addr == 8'h10) addr = 8'h11;
         run_txn(lsu, we, addr, wd, w, l, rd, wc, s, a, bus, p, cl);
         checks++;
         if (w !== 0 || l !== (we ? 2 : 3) || p !== 1 || a !== addr || cl !== 0) begin
            errors++;
            $display("FAIL rnd_timing i=%0d wait=%0d lat=%0d pulse=%0d addr=%h clash=%0d required 0/%0d/1/%h/0",
                     i, w, l, p, a, cl, (we ? 2 : 3), addr);
         end
         if (we) begin
            ref_mem[addr] = wd;
            checks++;
            if (bus !== wd || rd !== mdl_lsu_rdata || wc !== 1) begin
               errors++; $display("FAIL rnd_write i=%0d bus=%h hold=%h wec=%0d required %h/%h/1", i, bus, rd, wc, wd, mdl_lsu_rdata);
            end
         end else begin
            if (lsu) mdl_lsu_rdata = ref_mem[addr];
            checks++;
            if (rd !== ref_mem[addr] || wc !== 0) begin
               errors++; $display("FAIL rnd_read i=%0d data=%h wec=%0d required %h/0", i, rd, wc, ref_mem[addr]);
            end
         end
      end
   endtask

   task automatic test_contention();
      bit mdl_prefer_lsu, exp_lsu, got, got_lsu;
      int lsu_cnt;
      logic [AW-1:0] last_if_addr;
      apply_reset();
      mdl_prefer_lsu = 1'b1; lsu_cnt = 0;
      @(posedge clk); #1;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = AW'($urandom);
      if_req = 1'b1; if_addr = AW'($urandom); last_if_addr = if_addr;
      for (int g = 0; g < 4; g++) begin
         exp_lsu = lsu_req && (!if_req || !RR || mdl_prefer_lsu);
         got = 1'b0; got_lsu = 1'b0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (if_gnt && lsu_gnt) begin errors++; $display("FAIL cont_both_gnt g=%0d", g); end
            if (if_gnt || lsu_gnt) begin got = 1'b1; got_lsu = lsu_gnt; break; end
         end
         checks++;
         if (!got || got_lsu !== exp_lsu) begin
            errors++; $display("FAIL cont_order g=%0d granted=%0d lsu=%b required lsu=%b", g, got, got_lsu, exp_lsu);
         end
         if (!got) break;
         mdl_prefer_lsu = !got_lsu;
         @(posedge clk); #1;
         if (got_lsu) begin
            lsu_cnt++;
            if (lsu_cnt == 3) lsu_req = 1'b0;
            else lsu_addr = AW'($urandom);
         end else begin
            last_if_addr = if_addr;
            if_addr = AW'($urandom);
         end
      end
      lsu_req = 1'b0; if_req = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (if_rdata !== ref_mem[last_if_addr]) begin
         errors++; $display("FAIL cont_if_data actual=%h required %h", if_rdata, ref_mem[last_if_addr]);
      end
   endtask

   task automatic test_reset_mid_read();
      int w, l, wc, p, cl, rv; logic [DW-1:0] rd, bus; logic [2:0] s; logic [AW-1:0] a;
      run_txn(1'b0, 1'b0, 8'h10, '0, w, l, rd, wc, s, a, bus, p, cl);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 8'h30;
      @(posedge clk); #1;
      if_req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ram_oe !== 1'b1 || if_rdata === '0) begin
         errors++; $display("FAIL mid_pre oe=%b if_rdata=%h required 1/nonzero", ram_oe, if_rdata);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (if_rdata !== '0 || lsu_rdata !== '0) begin
         errors++; $display("FAIL mid_rdata if=%h lsu=%h required 0/0", if_rdata, lsu_rdata);
      end
      @(negedge clk); rst_n = 1'b1; mdl_lsu_rdata = '0;
      rv = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (if_rvalid || lsu_rvalid) rv++;
      end
      checks++;
      if (rv !== 0) begin errors++; $display("FAIL mid_no_rvalid actual=%0d required 0", rv); end
      run_txn(1'b0, 1'b0, 8'h10, '0, w, l, rd, wc, s, a, bus, p, cl);
      checks++;
      if (l !== 3 || rd !== ref_mem[8'h10]) begin
         errors++; $display("FAIL mid_recover lat=%0d data=%h required 3/%h", l, rd, ref_mem[8'h10]);
      end
   endtask

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
      mdl_lsu_rdata = '0;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = $urandom | 32'h1;
         ref_mem[i] = ram_mem[i];
      end
      ram_mem[8'h10] = 32'hDEADBEEF;
      ref_mem[8'h10] = 32'hDEADBEEF;
      test_reset();
      test_if_read();
      test_lsu_write_read();
      test_random();
      test_contention();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
